// File: rtl/sync_mon_pkg.sv
// Shared state encoding and done-marker constant for the
// lock-step divergence monitor.
package sync_mon_pkg;

   typedef enum logic [1:0] {
      SYNC     = 2'd0,
      DIVERGED = 2'd1,
      DONE     = 2'd2,
      TIMEOUT  = 2'd3
   } state_e;

   localparam logic [31:0] DONE_INST_DEF = 32'h0030_2013;

endpackage

// File: rtl/sync_mon_if.sv
// Probe/commit inputs and status outputs of the divergence
// monitor; master = harness side, slave = monitor side.
interface sync_mon_if #(
   parameter int NUM_CH = 2,
   parameter int CH_W   = 64,
   parameter int INST_W = 32,
   parameter int CNT_W  = 32
);

   logic [NUM_CH-1:0]      ch_enable;
   logic [NUM_CH-1:0]      dut_valid;
   logic [NUM_CH*CH_W-1:0] dut_data;
   logic [NUM_CH-1:0]      vnt_valid;
   logic [NUM_CH*CH_W-1:0] vnt_data;
   logic                   dut_commit_valid;
   logic [INST_W-1:0]      dut_commit_inst;
   logic                   vnt_commit_valid;
   logic [INST_W-1:0]      vnt_commit_inst;
   logic [CNT_W-1:0]       timeout_limit;

   logic                   sync;
   logic [NUM_CH-1:0]      diverge_ch;
   logic [CNT_W-1:0]       diverge_cycle;
   logic                   dut_done;
   logic                   vnt_done;
   logic                   finished;
   logic                   timeout;
   logic [CNT_W-1:0]       resync_count;

   modport master (
      output ch_enable, dut_valid, dut_data,
      output vnt_valid, vnt_data,
      output dut_commit_valid, dut_commit_inst,
      output vnt_commit_valid, vnt_commit_inst,
      output timeout_limit,
      input  sync, diverge_ch, diverge_cycle,
      input  dut_done, vnt_done, finished,
      input  timeout, resync_count
   );

   modport slave (
      input  ch_enable, dut_valid, dut_data,
      input  vnt_valid, vnt_data,
      input  dut_commit_valid, dut_commit_inst,
      input  vnt_commit_valid, vnt_commit_inst,
      input  timeout_limit,
      output sync, diverge_ch, diverge_cycle,
      output dut_done, vnt_done, finished,
      output timeout, resync_count
   );

endinterface

// File: rtl/sync_mon_lane.sv
// One compare lane: flags a valid or data difference on an
// enabled channel; data is don't-care when both valids are low.
module sync_mon_lane #(
   parameter int CH_W = 64
) (
   input  logic            en_i,
   input  logic            dut_valid_i,
   input  logic [CH_W-1:0] dut_data_i,
   input  logic            vnt_valid_i,
   input  logic [CH_W-1:0] vnt_data_i,
   output logic            mismatch_o
);

   logic vld_diff;
   logic dat_diff;

   assign vld_diff   = dut_valid_i != vnt_valid_i;
   assign dat_diff   = dut_valid_i && (dut_data_i != vnt_data_i);
   assign mismatch_o = en_i && (vld_diff || dat_diff);

endmodule

// File: rtl/sync_divergence_monitor.sv
// Lock-step DUT/variant divergence monitor with done/timeout
// tracking; SYNC_MON_RESYNC_EN enables return to lock-step.
module sync_divergence_monitor
   import sync_mon_pkg::*;
#(
`ifdef SYNC_MON_RESYNC_EN
   parameter int RESYNC_CYCLES = 16,
`endif
   parameter int                NUM_CH    = 2,
   parameter int                CH_W      = 64,
   parameter int                INST_W    = 32,
   parameter logic [INST_W-1:0] DONE_INST = INST_W'(DONE_INST_DEF),
   parameter int                CNT_W     = 32
) (
   input logic       clock,
   input logic       reset,
   sync_mon_if.slave bus
);

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [NUM_CH-1:0] mis;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      sync_mon_lane #(.CH_W(CH_W)) u_lane (
         .en_i       (bus.ch_enable[i]),
         .dut_valid_i(bus.dut_valid[i]),
         .dut_data_i (bus.dut_data[i*CH_W +: CH_W]),
         .vnt_valid_i(bus.vnt_valid[i]),
         .vnt_data_i (bus.vnt_data[i*CH_W +: CH_W]),
         .mismatch_o (mis[i])
      );
   end

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  div_q, div_d;
   logic [CNT_W-1:0]  dcyc_q, dcyc_d;
   logic [NUM_CH-1:0] dch_q, dch_d;
   logic              dd_q, dd_d;
   logic              vd_q, vd_d;

   logic any_mis;
   logic dut_hit;
   logic vnt_hit;
   logic dd_nx;
   logic vd_nx;
   logic tmo_hit;

   assign any_mis = |mis;
   assign dut_hit = bus.dut_commit_valid &&
                    (bus.dut_commit_inst == DONE_INST);
   assign vnt_hit = bus.vnt_commit_valid &&
                    (bus.vnt_commit_inst == DONE_INST);
   assign dd_nx   = dd_q || dut_hit;
   assign vd_nx   = vd_q || vnt_hit;
   assign tmo_hit = (bus.timeout_limit != '0) &&
                    (div_q == bus.timeout_limit - CNT_W'(1));

`ifdef SYNC_MON_RESYNC_EN
   logic [CNT_W-1:0] match_q, match_d;
   logic [CNT_W-1:0] rs_q, rs_d;
   logic             quiet;
   logic             rs_hit;

   assign quiet  = !any_mis && !dd_nx && !vd_nx;
   assign rs_hit = quiet &&
                   (match_q == CNT_W'(RESYNC_CYCLES - 1));
`endif

   always_comb begin
      state_d = state_q;
      cyc_d   = sat_inc(cyc_q);
      div_d   = div_q;
      dcyc_d  = dcyc_q;
      dch_d   = dch_q;
      dd_d    = dd_q;
      vd_d    = vd_q;
`ifdef SYNC_MON_RESYNC_EN
      match_d = '0;
      rs_d    = rs_q;
`endif
      unique case (state_q)
         SYNC: begin
            if (any_mis) begin
               state_d = DIVERGED;
               dch_d   = mis;
               dcyc_d  = cyc_q;
               div_d   = '0;
            end
         end
         DIVERGED: begin
            div_d = sat_inc(div_q);
            dd_d  = dd_nx;
            vd_d  = vd_nx;
`ifdef SYNC_MON_RESYNC_EN
            match_d = quiet ? sat_inc(match_q) : '0;
`endif
            // done has priority over a coincident timeout
            if (dd_nx && vd_nx) begin
               state_d = DONE;
            end else if (tmo_hit) begin
               state_d = TIMEOUT;
`ifdef SYNC_MON_RESYNC_EN
            end else if (rs_hit) begin
               state_d = SYNC;
               dch_d   = '0;
               dcyc_d  = '0;
               div_d   = '0;
               match_d = '0;
               rs_d    = sat_inc(rs_q);
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= SYNC;
         cyc_q   <= '0;
         div_q   <= '0;
         dcyc_q  <= '0;
         dch_q   <= '0;
         dd_q    <= 1'b0;
         vd_q    <= 1'b0;
`ifdef SYNC_MON_RESYNC_EN
         match_q <= '0;
         rs_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         div_q   <= div_d;
         dcyc_q  <= dcyc_d;
         dch_q   <= dch_d;
         dd_q    <= dd_d;
         vd_q    <= vd_d;
`ifdef SYNC_MON_RESYNC_EN
         match_q <= match_d;
         rs_q    <= rs_d;
`endif
      end
   end

   assign bus.sync          = state_q == SYNC;
   assign bus.diverge_ch    = dch_q;
   assign bus.diverge_cycle = dcyc_q;
   assign bus.dut_done      = dd_q;
   assign bus.vnt_done      = vd_q;
   assign bus.finished      = (state_q == DONE) ||
                              (state_q == TIMEOUT);
   assign bus.timeout       = state_q == TIMEOUT;
`ifdef SYNC_MON_RESYNC_EN
   assign bus.resync_count  = rs_q;
`else
   assign bus.resync_count  = '0;
`endif

endmodule

// File: doc/sync_divergence_monitor.md
Name: sync_divergence_monitor

Overview:
- Lock-step divergence monitor between the DUT harness and the variant harness in the parafuzz testbench.
- Compares NUM_CH probe channels (valid + data) each cycle. Records the first divergence: which channels mismatched and on which cycle.
- After divergence, tracks the commit streams of both harnesses until each retires the DONE_INST marker. Flags a timeout if the marker never arrives.
- Purely observational. It drives no DUT signals; its outputs feed testbench control and coverage.

Parameters:
- NUM_CH, 2, number of compared channels (e.g. BPD request PC, ROB enqueue inst).
- CH_W, 64, data width per channel; narrower signals are zero-extended by the instantiator.
- INST_W, 32, commit instruction width.
- DONE_INST, 32'h00302013, marker instruction that ends a run.
- CNT_W, 32, width of cycle and timeout counters.
- RESYNC_CYCLES, 16, consecutive matching cycles needed to resync (optional feature only).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ch_enable  in  NUM_CH  per-channel compare mask; 0 = channel ignored.
- dut_valid  in  NUM_CH  DUT channel valids.
- dut_data  in  NUM_CH*CH_W  DUT channel data; channel i occupies bits [i*CH_W +: CH_W].
- vnt_valid  in  NUM_CH  variant channel valids.
- vnt_data  in  NUM_CH*CH_W  variant channel data, same packing as dut_data.
- dut_commit_valid  in  1  DUT commit slot 0 valid.
- dut_commit_inst  in  INST_W  DUT commit slot 0 instruction.
- vnt_commit_valid  in  1  variant commit slot 0 valid.
- vnt_commit_inst  in  INST_W  variant commit slot 0 instruction.
- timeout_limit  in  CNT_W  max cycles from divergence to both-done; 0 disables timeout.
- sync  out  1  1 while harnesses are in lock-step.
- diverge_ch  out  NUM_CH  mask of channels that mismatched on the divergence cycle.
- diverge_cycle  out  CNT_W  cycle-counter value at divergence.
- dut_done  out  1  sticky; DUT committed DONE_INST after divergence.
- vnt_done  out  1  sticky; variant committed DONE_INST after divergence.
- finished  out  1  state is DONE or TIMEOUT.
- timeout  out  1  state is TIMEOUT.
- resync_count  out  CNT_W  number of resyncs; always 0 without the optional feature.

Behaviour:
- Reset (reset==0 at posedge): state=SYNC, sync=1, all other outputs 0, all counters 0. Reset mid-run aborts any state and clears sticky flags next cycle.
- cycle_cnt increments every non-reset cycle and saturates at all-ones.
- Channel i mismatch = ch_enable[i] && (dut_valid[i]!=vnt_valid[i] || (dut_valid[i] && dut_data[i]!=vnt_data[i])). Data is ignored when both valids are 0.
- SYNC: if any channel mismatches, go to DIVERGED at the next edge.
  - Register: sync=0, diverge_ch=mismatch vector, diverge_cycle=cycle_cnt (value before increment), div_cnt=0.
  - Outputs update one cycle after the mismatching inputs.
- DIVERGED:
  - div_cnt increments each cycle, saturating.
  - dut_done sets when dut_commit_valid && dut_commit_inst==DONE_INST; vnt_done likewise on the variant commit port.
  - Commits in the divergence cycle itself are not examined; marker checking starts the cycle after entry.
- DIVERGED -> DONE when dut_done and vnt_done are both set, counting flags set in the same cycle.
- DIVERGED -> TIMEOUT when timeout_limit!=0 and div_cnt==timeout_limit-1 with the done condition unmet.
- DONE wins when done and timeout coincide in the same cycle.
- DONE and TIMEOUT are terminal until reset; all outputs hold.
- Further mismatches after the first never alter diverge_ch or diverge_cycle.

Optional Feature:
- Macro: SYNC_MON_RESYNC_EN.
- Defined, in DIVERGED:
  - A match counter counts consecutive cycles with zero mismatches and neither done flag set; any mismatch clears it.
  - When it reaches RESYNC_CYCLES: return to SYNC, sync=1, clear diverge_ch, diverge_cycle and div_cnt, increment resync_count (saturating).
  - A later divergence re-captures diverge_ch and diverge_cycle.
- Undefined: DIVERGED leaves only via DONE or TIMEOUT; resync_count tied to 0.

Decomposition:
- Package sync_mon_pkg: state enum (SYNC, DIVERGED, DONE, TIMEOUT) and the default DONE_INST constant.
- Sub-module sync_mon_lane: per-channel combinational mismatch lane (enable, two valids, two data), instantiated NUM_CH times via generate.

Test Plan:
- Identical streams on both channels for 1000 cycles -> sync stays 1; diverge_ch=0; finished=0.
- Cycle 50: ch1 data differs (0x8000_0010 vs 0x8000_0014), both valid -> at cycle 51 sync=0, diverge_ch=2'b10, diverge_cycle=50.
- Valid mismatch on ch0 with ch_enable=2'b10 -> no divergence. Same stimulus with ch_enable=2'b11 -> diverge_ch=2'b01.
- After divergence, DUT commits 0x00302013 at +5 and variant at +9 -> dut_done at +6, vnt_done at +10, DONE state; finished=1, timeout=0.
- timeout_limit=20, only the DUT commits the marker -> timeout=1 exactly 20 cycles after divergence; dut_done=1, vnt_done=0. Reset low for one cycle -> all outputs return to reset values.
- With SYNC_MON_RESYNC_EN, RESYNC_CYCLES=16: single-cycle mismatch then 16 matching cycles -> sync returns to 1, resync_count=1, diverge_ch cleared.
